btn_add_sub: RTL and testbench

- 2-bit registered adder/subtractor whose operation is chosen by two push-button inputs.
- btn1 selects ADD mode; btn2 selects SUB mode; the selected mode is held after the button is released.
- Sits behind board switches/buttons (A, B, Cin) and drives LEDs (S, C0).
- Outputs are registered on clk with one-cycle latency.

---
 rtl/btn_add_sub.sv | 106 ++++++++++
 tb/tb_btn_add_sub.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/btn_add_sub.sv
// Registered 2-bit-style adder/subtractor whose ADD/SUB mode is latched from push buttons.
// Optional BTN_SYNC_EN adds a two-flop synchronizer on each button ahead of mode decoding.
module btn_add_sub #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             btn1,
  input  logic             btn2,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             C0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2
  } mode_t;

  mode_t            r_mode;
  mode_t            w_op;
  logic             w_btn1;
  logic             w_btn2;
  logic [WIDTH-1:0] r_s;
  logic             r_c0;
  logic [WIDTH-1:0] w_s_next;
  logic             w_c0_next;
  logic [WIDTH:0]   w_cin_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;

`ifdef BTN_SYNC_EN
  logic [1:0] r_btn1_sync;
  logic [1:0] r_btn2_sync;

  // NOTE: non-blocking assignments for every flop so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn1_sync <= 2'b00;
      r_btn2_sync <= 2'b00;
    end else begin
      r_btn1_sync <= {r_btn1_sync[0], btn1};
      r_btn2_sync <= {r_btn2_sync[0], btn2};
    end
  end

  assign w_btn1 = r_btn1_sync[1];
  assign w_btn2 = r_btn2_sync[1];
`else
  assign w_btn1 = btn1;
  assign w_btn2 = btn2;
`endif

  assign w_cin_ext = {{WIDTH{1'b0}}, Cin};
  assign w_sum     = {1'b0, A} + {1'b0, B} + w_cin_ext;
  // The top bit of the (WIDTH+1)-bit difference is set exactly when A < B + Cin.
  assign w_diff    = {1'b0, A} - {1'b0, B} - w_cin_ext;

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_op = r_mode;
    case ({w_btn1, w_btn2})
      2'b10:   w_op = ADD;
      2'b01:   w_op = SUB;
      default: w_op = r_mode;
    endcase
  end

  always_comb begin
    w_s_next  = '0;
    w_c0_next = 1'b0;
    case (w_op)
      ADD: begin
        w_s_next  = w_sum[WIDTH-1:0];
        w_c0_next = w_sum[WIDTH];
      end
      SUB: begin
        w_s_next  = w_diff[WIDTH-1:0];
        w_c0_next = w_diff[WIDTH];
      end
      default: begin
        w_s_next  = '0;
        w_c0_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= IDLE;
      r_s    <= '0;
      r_c0   <= 1'b0;
    end else begin
      r_mode <= w_op;
      r_s    <= w_s_next;
      r_c0   <= w_c0_next;
    end
  end

  assign S  = r_s;
  assign C0 = r_c0;

endmodule

// File: tb/tb_btn_add_sub.sv
// Scoreboard bench for btn_add_sub: a reference model queues expected S/C0 per edge,
// and an independent monitor compares them against the DUT on the falling edge.
module tb_btn_add_sub;

  localparam int WIDTH = 2;
  localparam int MODULUS = 1 << WIDTH;

  typedef struct {
    int s;
    int c0;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             btn1 = 1'b0;
  logic             btn2 = 1'b0;
  logic             Cin = 1'b0;
  logic [WIDTH-1:0] S;
  logic             C0;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  // Reference model state: 0 = idle, 1 = add, 2 = sub
  int   model_mode = 0;
  int   b1_hist[2] = '{0, 0};
  int   b2_hist[2] = '{0, 0};

  btn_add_sub #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .btn1 (btn1),
    .btn2 (btn2),
    .Cin  (Cin),
    .S    (S),
    .C0   (C0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t model_step(input int r, input int a, input int b,
                                      input int p1, input int p2, input int cin);
    exp_t e;
    int   e1, e2, total;
`ifdef BTN_SYNC_EN
    e1 = b1_hist[1];
    e2 = b2_hist[1];
    b1_hist[1] = b1_hist[0];
    b2_hist[1] = b2_hist[0];
    b1_hist[0] = p1;
    b2_hist[0] = p2;
`else
    e1 = p1;
    e2 = p2;
`endif
    e.s  = 0;
    e.c0 = 0;
    if (r != 0) begin
      model_mode = 0;
      b1_hist = '{0, 0};
      b2_hist = '{0, 0};
      return e;
    end
    if (e1 == 1 && e2 == 0) model_mode = 1;
    else if (e1 == 0 && e2 == 1) model_mode = 2;
    if (model_mode == 1) begin
      total = a + b + cin;
      e.s  = total % MODULUS;
      e.c0 = (total >= MODULUS) ? 1 : 0;
    end else if (model_mode == 2) begin
      total = a - b - cin;
      e.s  = (total + 2 * MODULUS) % MODULUS;
      e.c0 = (a < b + cin) ? 1 : 0;
    end
    return e;
  endfunction

  // Drive one cycle of inputs shortly after a rising edge; the expectation is queued
  // at the edge that samples them.
  task automatic apply(input int r, input int a, input int b,
                       input int p1, input int p2, input int cin);
    exp_t e;
    rst  = r[0];
    A    = a[WIDTH-1:0];
    B    = b[WIDTH-1:0];
    btn1 = p1[0];
    btn2 = p2[0];
    Cin  = cin[0];
    e = model_step(r, a, b, p1, p2, cin);
    @(posedge clk);
    exp_q.push_back(e);
    n_pushed++;
    #1;
  endtask

  // Monitor: the DUT presents a fresh result every cycle after an edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        check("S",  int'(S),  e.s);
        check("C0", int'(C0), e.c0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    @(posedge clk);
    #1;
    // Reset with conflicting live inputs, then release with buttons idle
    apply(1, 3, 3, 1, 0, 1);
    apply(1, 3, 3, 1, 0, 1);
    apply(0, 3, 3, 0, 0, 1);
    apply(0, 1, 2, 0, 0, 0);
    // ADD
    apply(0, 2, 1, 1, 0, 0);
    apply(0, 2, 1, 1, 0, 1);
    apply(0, 3, 3, 1, 0, 1);
    // SUB, including equal operands and underflow
    apply(0, 2, 1, 0, 1, 0);
    apply(0, 1, 2, 0, 1, 0);
    apply(0, 2, 2, 0, 1, 0);
    apply(0, 0, 3, 0, 1, 1);
    // Mode hold after release and with both buttons pressed
    apply(0, 3, 1, 0, 0, 1);
    apply(0, 3, 1, 1, 1, 1);
    apply(0, 2, 3, 1, 1, 0);
    // Button change mid-stream (exposes synchronizer delay when enabled)
    apply(0, 1, 1, 1, 0, 0);
    apply(0, 1, 1, 1, 0, 0);
    apply(0, 1, 1, 1, 0, 0);
    apply(0, 3, 2, 0, 1, 0);
    apply(0, 3, 2, 0, 0, 0);
    apply(0, 3, 2, 0, 0, 0);
    apply(0, 3, 2, 0, 0, 0);
    // Reset mid-operation loses the stored mode
    apply(1, 3, 3, 0, 0, 1);
    apply(0, 3, 3, 0, 0, 1);
    // Exhaustive sweep in each mode, buttons released after selection
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) apply(0, 0, 0, (m == 0) ? 1 : 0, (m == 1) ? 1 : 0, 0);
      for (int a = 0; a < MODULUS; a++)
        for (int b = 0; b < MODULUS; b++)
          for (int c = 0; c < 2; c++)
            apply(0, a, b, 0, 0, c);
    end
    // Randomized traffic with occasional reset and mixed button presses
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      apply(($urandom_range(0, 31) == 0) ? 1 : 0,
            $urandom_range(0, MODULUS - 1), $urandom_range(0, MODULUS - 1),
            (r == 0 || r == 2) ? 1 : 0, (r == 1 || r == 2) ? 1 : 0,
            $urandom_range(0, 1));
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("all_results_seen", n_popped, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
